// File: rtl/stereo_frame_ctrl.sv
// Frame sequencer for the census stereo core: pixel-pair handshake in, zero-pad drain, tagged
// disparity results out. Optional build macro: STEREO_CTRL_BORDER_MASK_EN.
module stereo_frame_ctrl #(
  parameter int unsigned IMG_W     = 320,
  parameter int unsigned IMG_H     = 240,
  parameter int unsigned DISPARITY = 80,
  parameter int unsigned WIN_W     = 11,
  parameter int unsigned WIN_H     = 11,
  parameter int unsigned PIPE_LAT  = 12,
  localparam int unsigned DW = $clog2(DISPARITY),
  localparam int unsigned XW = $clog2(IMG_W),
  localparam int unsigned YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          pad_sel,
  output logic          core_en,
  input  logic [DW-1:0] core_disp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_disp,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_sof,
  output logic          out_eof,
  output logic          out_border,
  output logic          busy
);

  localparam int unsigned CW      = $clog2(PIPE_LAT + 1);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
  localparam logic [CW-1:0] LatCnt = CW'(PIPE_LAT);
  localparam int unsigned BorderX = WIN_W + DISPARITY - 2;
  localparam int unsigned BorderY = WIN_H - 1;

`ifdef STEREO_CTRL_BORDER_MASK_EN
  localparam bit BorderMaskEn = 1'b1;
`else
  localparam bit BorderMaskEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StFill, StStream, StFlush} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] in_x_q, in_x_d, out_x_q, out_x_d;
  logic [YW-1:0] in_y_q, in_y_d, out_y_q, out_y_d;
  logic [CW-1:0] lat_cnt_q, lat_cnt_d;
  logic          out_valid_q, out_valid_d;

  logic can_adv, accept, out_hs, produce, in_last, border_raw;

  // Handshake and core enable; the only input-to-output combinational paths.
  always_comb begin
    can_adv  = !out_valid_q || out_ready;
    in_ready = (state_q != StFlush) && can_adv;
    pad_sel  = (state_q == StFlush);
    accept   = in_valid && in_ready;
    if (state_q == StFlush) begin
      // Stop advancing once the drain steps are spent; only the eof handshake remains.
      core_en = can_adv && (lat_cnt_q != LatCnt);
    end else begin
      core_en = accept;
    end
    produce = core_en && ((state_q == StStream) || (state_q == StFlush));
    out_hs  = out_valid_q && out_ready;
    in_last = (in_x_q == XLast) && (in_y_q == YLast);
  end

  // lat_cnt counts fill accepts, then is reused to count drain advances.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (PIPE_LAT <= 1) begin
            state_d   = StStream;
            lat_cnt_d = '0;
          end else begin
            state_d   = StFill;
            lat_cnt_d = CW'(1);
          end
        end
      end
      StFill: begin
        if (accept) begin
          if (lat_cnt_q + CW'(1) == LatCnt) begin
            state_d   = StStream;
            lat_cnt_d = '0;
          end else begin
            lat_cnt_d = lat_cnt_q + CW'(1);
          end
        end
      end
      StStream: begin
        if (accept && in_last) begin
          state_d   = StFlush;
          lat_cnt_d = '0;
        end
      end
      StFlush: begin
        if (core_en) begin
          lat_cnt_d = lat_cnt_q + CW'(1);
        end
        if (out_hs && out_eof) begin
          state_d   = StIdle;
          lat_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    in_x_d  = in_x_q;
    in_y_d  = in_y_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (accept) begin
      if (in_x_q == XLast) begin
        in_x_d = '0;
        in_y_d = (in_y_q == YLast) ? '0 : in_y_q + YW'(1);
      end else begin
        in_x_d = in_x_q + XW'(1);
      end
    end
    if (out_hs) begin
      if (out_x_q == XLast) begin
        out_x_d = '0;
        out_y_d = (out_y_q == YLast) ? '0 : out_y_q + YW'(1);
      end else begin
        out_x_d = out_x_q + XW'(1);
      end
    end
    // A producing step in the handshake cycle reloads rather than clears.
    if (produce) begin
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_x_q      <= '0;
      in_y_q      <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      lat_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_x_q      <= in_x_d;
      in_y_q      <= in_y_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      lat_cnt_q   <= lat_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    out_valid  = out_valid_q;
    out_x      = out_x_q;
    out_y      = out_y_q;
    out_sof    = (out_x_q == '0) && (out_y_q == '0);
    out_eof    = (out_x_q == XLast) && (out_y_q == YLast);
    border_raw = (32'(out_y_q) < BorderY) || (32'(out_x_q) < BorderX);
    out_border = BorderMaskEn && border_raw;
    // Core holds outp while en is low, so this stays stable through a stall.
    out_disp   = out_border ? '0 : core_disp;
    busy       = (state_q != StIdle);
  end

endmodule
